// File: rtl/pc_pkg.sv
// pc_pkg: shared types and helpers for the fetch-stage program counter.
//   pc_state_e : FSM states (idle, running, holding a pending redirect).
//   pc_src_e   : source selected for the next pc value.
//   align_lsb  : number of low pc bits that must be zero for an aligned target.
package pc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHold
    } pc_state_e;

    typedef enum logic [2:0] {
        SrcNone,
        SrcSeq,
        SrcBr,
        SrcExc,
        SrcPendBr,
        SrcPendExc
    } pc_src_e;

    function automatic int unsigned align_lsb(input int unsigned inst_bytes);
        return (inst_bytes <= 1) ? 0 : $clog2(inst_bytes);
    endfunction

endpackage

// File: rtl/pc_redirect_latch.sv
// pc_redirect_latch: holds one redirect that arrived while the pipe was stalled.
// An exception request always overwrites the entry; a branch request only
// overwrites an empty entry or a pending branch, never a pending exception.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-low reset
//   clear_i        drop the entry (wins over capture_i)
//   capture_i      accept exc_i / br_i this cycle
//   exc_i          exception request (target EXC_VEC)
//   exc_mis_i      exception was caused by a misaligned branch target
//   br_i           branch request, target br_target_i
//   valid_o        entry held
//   is_exc_o       held entry is an exception
//   mis_o          held exception came from a misaligned branch
//   target_o       held target
module pc_redirect_latch
    import pc_pkg::*;
#(
    parameter int unsigned          ADDR_W  = 32,
    parameter logic [ADDR_W-1:0]    EXC_VEC = ADDR_W'(32'h0000_0080)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              capture_i,
    input  logic              exc_i,
    input  logic              exc_mis_i,
    input  logic              br_i,
    input  logic [ADDR_W-1:0] br_target_i,
    output logic              valid_o,
    output logic              is_exc_o,
    output logic              mis_o,
    output logic [ADDR_W-1:0] target_o
);

    logic              valid_q, valid_d;
    logic              is_exc_q, is_exc_d;
    logic              mis_q, mis_d;
    logic [ADDR_W-1:0] target_q, target_d;

    always_comb begin
        valid_d  = valid_q;
        is_exc_d = is_exc_q;
        mis_d    = mis_q;
        target_d = target_q;
        if (clear_i) begin
            valid_d  = 1'b0;
            is_exc_d = 1'b0;
            mis_d    = 1'b0;
            target_d = '0;
        end else if (capture_i) begin
            if (exc_i) begin
                valid_d  = 1'b1;
                is_exc_d = 1'b1;
                mis_d    = exc_mis_i;
                target_d = EXC_VEC;
            end else if (br_i && !(valid_q && is_exc_q)) begin
                valid_d  = 1'b1;
                is_exc_d = 1'b0;
                mis_d    = 1'b0;
                target_d = br_target_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q  <= 1'b0;
            is_exc_q <= 1'b0;
            mis_q    <= 1'b0;
            target_q <= '0;
        end else begin
            valid_q  <= valid_d;
            is_exc_q <= is_exc_d;
            mis_q    <= mis_d;
            target_q <= target_d;
        end
    end

    assign valid_o  = valid_q;
    assign is_exc_o = is_exc_q;
    assign mis_o    = mis_q;
    assign target_o = target_q;

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter at the head of the fetch stage.
// Sequential fetch, prioritised exception/branch redirects, any-of-N stall,
// and a pending-redirect latch so redirects arriving during a stall survive.
// Optional macro PC_ALIGN_CHECK_EN: misaligned branch targets become exception
// redirects and misalign_o pulses when one is applied; without it the low
// alignment bits of the branch target are forced to zero.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-low reset
//   start_i          run enable; low returns to idle at RESET_VEC
//   stall_i          stall requests, any bit set freezes pc_o
//   br_valid_i       branch redirect, target br_target_i
//   exc_valid_i      exception redirect, target EXC_VEC
//   pc_o             current fetch address
//   pc_seq_o         pc_o + INST_BYTES (wraps)
//   pc_valid_o       fetch address valid (running or holding)
//   redirect_pend_o  a redirect is waiting for the stall to clear
//   misalign_o       (PC_ALIGN_CHECK_EN only) misaligned-target exception applied
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
    parameter logic [ADDR_W-1:0] EXC_VEC    = ADDR_W'(32'h0000_0080),
    parameter int unsigned       INST_BYTES = 4,
    parameter int unsigned       NUM_STALL  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [NUM_STALL-1:0] stall_i,
    input  logic                 br_valid_i,
    input  logic [ADDR_W-1:0]    br_target_i,
    input  logic                 exc_valid_i,
    output logic [ADDR_W-1:0]    pc_o,
    output logic [ADDR_W-1:0]    pc_seq_o,
    output logic                 pc_valid_o,
    output logic                 redirect_pend_o
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic                 misalign_o
`endif
);

    localparam int unsigned       AlignLsb  = align_lsb(INST_BYTES);
    // All-zero when INST_BYTES is 1, which disables alignment handling.
    localparam logic [ADDR_W-1:0] AlignMask =
        (AlignLsb == 0) ? '0 : ADDR_W'((64'd1 << AlignLsb) - 64'd1);

    pc_state_e         state_q;
    logic [ADDR_W-1:0] pc_q, pc_seq, pc_next, br_tgt;
    logic              pc_valid_q;
    logic              stall, br_ok, exc_req, exc_mis;
    pc_src_e           src;

    logic              pend_valid, pend_exc, pend_mis;
    logic [ADDR_W-1:0] pend_target;

    assign stall  = |stall_i;
    assign pc_seq = pc_q + ADDR_W'(INST_BYTES);

`ifdef PC_ALIGN_CHECK_EN
    logic br_mis;
    logic mis_next;
    logic misalign_q;

    assign br_mis  = |(br_target_i & AlignMask);
    assign br_ok   = br_valid_i & ~br_mis;
    assign exc_req = exc_valid_i | (br_valid_i & br_mis);
    // A real exception in the same cycle is the cause, not the misalignment.
    assign exc_mis = br_valid_i & br_mis & ~exc_valid_i;
    assign br_tgt  = br_target_i;
    assign mis_next = ((src == SrcExc) & exc_mis) | ((src == SrcPendExc) & pend_mis);
`else
    logic unused_pend_mis;

    assign br_ok   = br_valid_i;
    assign exc_req = exc_valid_i;
    assign exc_mis = 1'b0;
    assign br_tgt  = br_target_i & ~AlignMask;
    assign unused_pend_mis = pend_mis;
`endif

    // Next-pc source; the HOLD exit never falls back to the sequential address.
    always_comb begin
        src = SrcNone;
        unique case (state_q)
            StRun: begin
                if (!stall) begin
                    src = exc_req ? SrcExc : (br_ok ? SrcBr : SrcSeq);
                end
            end
            StHold: begin
                if (!stall) begin
                    src = exc_req  ? SrcExc     :
                          pend_exc ? SrcPendExc :
                          br_ok    ? SrcBr      : SrcPendBr;
                end
            end
            default: src = SrcNone;
        endcase
    end

    always_comb begin
        pc_next = pc_q;
        unique case (src)
            SrcSeq:             pc_next = pc_seq;
            SrcBr:              pc_next = br_tgt;
            SrcExc, SrcPendExc: pc_next = EXC_VEC;
            SrcPendBr:          pc_next = pend_target;
            default:            pc_next = pc_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= StIdle;
            pc_q       <= RESET_VEC;
            pc_valid_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
`ifdef PC_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
            unique case (state_q)
                StRun, StHold: begin
                    if (!start_i) begin
                        state_q    <= StIdle;
                        pc_q       <= RESET_VEC;
                        pc_valid_q <= 1'b0;
                    end else if (stall) begin
                        if (state_q == StRun && (exc_req || br_ok)) begin
                            state_q <= StHold;
                        end
                    end else begin
                        state_q <= StRun;
                        pc_q    <= pc_next;
`ifdef PC_ALIGN_CHECK_EN
                        misalign_q <= mis_next;
`endif
                    end
                end
                default: begin
                    pc_q <= RESET_VEC;
                    if (start_i) begin
                        state_q    <= StRun;
                        pc_valid_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    pc_redirect_latch #(
        .ADDR_W  (ADDR_W),
        .EXC_VEC (EXC_VEC)
    ) u_latch (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     ((state_q != StIdle) && (!start_i || !stall)),
        .capture_i   ((state_q != StIdle) && start_i && stall),
        .exc_i       (exc_req),
        .exc_mis_i   (exc_mis),
        .br_i        (br_ok),
        .br_target_i (br_tgt),
        .valid_o     (pend_valid),
        .is_exc_o    (pend_exc),
        .mis_o       (pend_mis),
        .target_o    (pend_target)
    );

    assign pc_o            = pc_q;
    assign pc_seq_o        = pc_seq;
    assign pc_valid_o      = pc_valid_q;
    assign redirect_pend_o = pend_valid;
`ifdef PC_ALIGN_CHECK_EN
    assign misalign_o      = misalign_q;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: drives a 32-bit and an 8-bit pc_unit with the same stimulus and
// compares both every cycle against a behavioural model, plus directed
// literal expectations. Honours PC_ALIGN_CHECK_EN when defined.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  stall;
    logic        br_v;
    logic [31:0] br_t;
    logic        exc_v;

    logic [31:0] pc0, seq0;
    logic        val0, pend0;
    logic [7:0]  pc1, seq1;
    logic        val1, pend1;
`ifdef PC_ALIGN_CHECK_EN
    logic        mis0, mis1;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    // Model state, index 0 = 32-bit instance, 1 = 8-bit instance.
    logic [31:0] m_pc[2];
    bit          m_run[2];
    bit          m_pv[2];
    bit          m_pe[2];
    bit          m_pm[2];
    logic [31:0] m_pt[2];
    bit          m_mis[2];

    always #5 clk = ~clk;

    pc_unit dut (
        .clk_i           (clk),
        .rst_i           (rst_n),
        .start_i         (start),
        .stall_i         (stall),
        .br_valid_i      (br_v),
        .br_target_i     (br_t),
        .exc_valid_i     (exc_v),
        .pc_o            (pc0),
        .pc_seq_o        (seq0),
        .pc_valid_o      (val0),
        .redirect_pend_o (pend0)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misalign_o      (mis0)
`endif
    );

    pc_unit #(
        .ADDR_W  (8),
        .EXC_VEC (8'h80)
    ) dut8 (
        .clk_i           (clk),
        .rst_i           (rst_n),
        .start_i         (start),
        .stall_i         (stall),
        .br_valid_i      (br_v),
        .br_target_i     (br_t[7:0]),
        .exc_valid_i     (exc_v),
        .pc_o            (pc1),
        .pc_seq_o        (seq1),
        .pc_valid_o      (val1),
        .redirect_pend_o (pend1)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misalign_o      (mis1)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] msk(input int i);
        return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = 32'h0; m_run[i] = 0; m_pv[i] = 0; m_pe[i] = 0;
            m_pm[i] = 0; m_pt[i] = 32'h0; m_mis[i] = 0;
        end
    endtask

    // One clock edge of the spec's rules; a pending entry means "holding".
    task automatic model_step(input int i);
        logic [31:0] t;
        bit mis, br_ok, exc_new, cause;
        t = br_t & msk(i);
        mis = 0;
`ifdef PC_ALIGN_CHECK_EN
        mis = br_v && (t[1:0] != 2'b00);
`else
        t = t & ~32'h3;
`endif
        br_ok   = br_v && !mis;
        exc_new = exc_v || mis;
        cause   = mis && !exc_v;
        m_mis[i] = 0;
        if (!m_run[i]) begin
            m_pc[i]  = 32'h0;
            m_run[i] = start;
        end else if (!start) begin
            m_run[i] = 0; m_pc[i] = 32'h0;
            m_pv[i] = 0; m_pe[i] = 0; m_pm[i] = 0;
        end else if (stall != 2'b00) begin
            if (exc_new) begin
                m_pv[i] = 1; m_pe[i] = 1; m_pm[i] = cause; m_pt[i] = 32'h80;
            end else if (br_ok && !(m_pv[i] && m_pe[i])) begin
                m_pv[i] = 1; m_pe[i] = 0; m_pm[i] = 0; m_pt[i] = t;
            end
        end else begin
            if (exc_new) begin
                m_pc[i] = 32'h80; m_mis[i] = cause;
            end else if (m_pv[i] && m_pe[i]) begin
                m_pc[i] = 32'h80; m_mis[i] = m_pm[i];
            end else if (br_ok) begin
                m_pc[i] = t;
            end else if (m_pv[i]) begin
                m_pc[i] = m_pt[i];
            end else begin
                m_pc[i] = (m_pc[i] + 32'd4) & msk(i);
            end
            m_pv[i] = 0; m_pe[i] = 0; m_pm[i] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            model_step(0);
            model_step(1);
        end
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
    endtask

    task automatic drive(input bit s, input logic [1:0] st, input bit bv, input logic [31:0] bt,
                         input bit ev);
        start = s; stall = st; br_v = bv; br_t = bt; exc_v = ev;
    endtask

    // Single compare process: every negedge, both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("pc0", pc0, m_pc[0]);
            check("seq0", seq0, m_pc[0] + 32'd4);
            check("valid0", {31'b0, val0}, {31'b0, m_run[0]});
            check("pend0", {31'b0, pend0}, {31'b0, m_pv[0]});
            check("pc1", {24'b0, pc1}, m_pc[1]);
            check("seq1", {24'b0, seq1}, (m_pc[1] + 32'd4) & 32'hFF);
            check("valid1", {31'b0, val1}, {31'b0, m_run[1]});
            check("pend1", {31'b0, pend1}, {31'b0, m_pv[1]});
`ifdef PC_ALIGN_CHECK_EN
            check("mis0", {31'b0, mis0}, {31'b0, m_mis[0]});
            check("mis1", {31'b0, mis1}, {31'b0, m_mis[1]});
`endif
        end
    end

    initial begin
        drive(0, 2'b00, 0, 32'h0, 0);
        do_reset();
        #1 chk_on = 1'b1;
        #11 rst_n = 1'b1;

        // Reset state and start sequence.
        tick();
        check("reset_pc", pc0, 32'h0);
        check("reset_valid", {31'b0, val0}, 32'h0);
        check("reset_pend", {31'b0, pend0}, 32'h0);
        start = 1'b1;
        tick();
        check("first_fetch_pc", pc0, 32'h0);
        check("first_fetch_valid", {31'b0, val0}, 32'h1);
        tick();
        check("seq_4", pc0, 32'h4);
        tick();
        check("seq_8", pc0, 32'h8);
        tick();
        tick();
        check("seq_10", pc0, 32'h10);

        // Cache stall for three cycles.
        stall = 2'b10;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_hold", pc0, 32'h10);
        end
        stall = 2'b00;
        tick();
        check("stall_release", pc0, 32'h14);

        // Branch arriving during a hazard stall.
        drive(1, 2'b01, 1, 32'h200, 0);
        tick();
        check("pend_set", {31'b0, pend0}, 32'h1);
        check("pend_pc_held", pc0, 32'h14);
        drive(1, 2'b00, 0, 32'h0, 0);
        tick();
        check("pend_apply", pc0, 32'h200);
        check("pend_clear", {31'b0, pend0}, 32'h0);

        // Pending exception is not overwritten by a later branch.
        drive(1, 2'b01, 0, 32'h0, 1);
        tick();
        drive(1, 2'b01, 1, 32'h300, 0);
        tick();
        check("exc_hold_pc", pc0, 32'h200);
        check("exc_hold_pend", {31'b0, pend0}, 32'h1);
        drive(1, 2'b00, 0, 32'h0, 0);
        tick();
        check("exc_protected", pc0, 32'h80);
        tick();
        check("after_exc_seq", pc0, 32'h84);
        drive(1, 2'b00, 1, 32'h400, 1);
        tick();
        check("exc_over_br", pc0, 32'h80);

        // Wrap on the 8-bit instance.
        drive(1, 2'b00, 1, 32'hFC, 0);
        tick();
        check("wrap_pre", {24'b0, pc1}, 32'hFC);
        check("wrap_seq_o", {24'b0, seq1}, 32'h00);
        drive(1, 2'b00, 0, 32'h0, 0);
        tick();
        check("wrap_pc8", {24'b0, pc1}, 32'h00);
        check("nowrap_pc32", pc0, 32'h100);

        // Dropping start while holding a redirect.
        drive(1, 2'b01, 1, 32'h20, 0);
        tick();
        check("hold_before_drop", {31'b0, pend0}, 32'h1);
        drive(0, 2'b01, 0, 32'h0, 0);
        tick();
        check("drop_pc", pc0, 32'h0);
        check("drop_pend", {31'b0, pend0}, 32'h0);
        check("drop_valid", {31'b0, val0}, 32'h0);
        drive(1, 2'b00, 0, 32'h0, 0);
        tick();
        check("restart_pc", pc0, 32'h0);

        // Misaligned branch target.
        drive(1, 2'b00, 1, 32'h102, 0);
        tick();
`ifdef PC_ALIGN_CHECK_EN
        check("misalign_pc", pc0, 32'h80);
        check("misalign_pulse", {31'b0, mis0}, 32'h1);
`else
        check("align_forced", pc0, 32'h100);
`endif
        drive(1, 2'b00, 0, 32'h0, 0);
        tick();
`ifdef PC_ALIGN_CHECK_EN
        check("misalign_once", {31'b0, mis0}, 32'h0);
`else
        check("align_next", pc0, 32'h104);
`endif

        // Asynchronous reset from a non-reset pc.
        drive(1, 2'b00, 1, 32'h40, 0);
        tick();
        check("pre_reset_pc", pc0, 32'h40);
        drive(1, 2'b00, 0, 32'h0, 0);
        #1;
        do_reset();
        #1;
        check("async_reset_pc", pc0, 32'h0);
        check("async_reset_valid", {31'b0, val0}, 32'h0);
        tick();
        rst_n = 1'b1;

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] t;
            start = ($urandom_range(0, 99) != 0);
            stall = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            br_v  = ($urandom_range(0, 4) == 0);
            exc_v = ($urandom_range(0, 11) == 0);
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            br_t = t;
            if ($urandom_range(0, 499) == 0) begin
                #1;
                do_reset();
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter block at the head of the fetch stage.
- Supersedes the fixed 32-bit, two-stall PC register with:
  - configurable address width, reset vector and instruction size;
  - N independent stall sources;
  - prioritised branch and exception redirects;
  - a pending-redirect latch, so redirects that arrive while the pipe is frozen (hazard stall, cache stall) are not lost.

Parameters:
- ADDR_W, 32: PC width in bits.
- RESET_VEC, 0: PC value after reset and while not started.
- EXC_VEC, 32'h0000_0080: exception handler entry address.
- INST_BYTES, 4: sequential increment. Must be a power of two, at least 1.
- NUM_STALL, 2: number of stall request inputs (bit 0 hazard, bit 1 cache by convention).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  run enable; low forces IDLE.
- stall_i  in  NUM_STALL  stall requests; any bit set freezes pc_o.
- br_valid_i  in  1  branch/jump redirect request, single cycle.
- br_target_i  in  ADDR_W  branch target.
- exc_valid_i  in  1  exception redirect request, single cycle; target is EXC_VEC.
- pc_o  out  ADDR_W  current fetch address.
- pc_seq_o  out  ADDR_W  pc_o + INST_BYTES, combinational, mod 2^ADDR_W.
- pc_valid_o  out  1  high in RUN.
- redirect_pend_o  out  1  pending redirect held.

Behaviour:
- Reset (rst_i low, asynchronous):
  - pc_o = RESET_VEC; state = IDLE; pc_valid_o = 0.
  - Pending latch cleared; redirect_pend_o = 0.
  - Reset asserted mid-stall discards any pending redirect.
- States: IDLE, RUN, HOLD.
- stall = OR of all stall_i bits.
- IDLE:
  - pc_o held at RESET_VEC; pc_valid_o = 0.
  - All redirect inputs ignored.
  - start_i = 1 -> RUN at the next edge, with pc_o still RESET_VEC. The first valid fetch address is therefore RESET_VEC.
- RUN, stall = 0:
  - pc_o <= next, selected by priority: exc_valid_i -> EXC_VEC; br_valid_i -> br_target_i; otherwise pc_seq_o.
- RUN, stall = 1:
  - pc_o held.
  - If exc_valid_i or br_valid_i: capture the highest-priority target and an is_exc flag into the pending latch, then -> HOLD.
  - Otherwise stay in RUN.
- HOLD:
  - pc_o held; redirect_pend_o = 1; pc_valid_o = 1.
  - New request while still stalled: exc_valid_i overwrites any pending entry. br_valid_i overwrites only a pending branch, never a pending exception.
  - First cycle with stall = 0, pc_o <= next, selected by priority: new exc > pending exc > new br > pending br.
  - On that edge, clear the latch and -> RUN. Sequential increment is never used on the HOLD exit edge.
- start_i = 0 in RUN or HOLD (synchronous):
  - Next edge: pc_o = RESET_VEC, latch cleared, -> IDLE.
  - Overrides stall and all redirects.
- Arithmetic: pc_seq_o wraps modulo 2^ADDR_W; no overflow flag.
- Branch-target alignment: see the optional feature below.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Adds output misalign_o (1 bit, reset 0).
  - A br_target_i with any of its low log2(INST_BYTES) bits nonzero is treated as an exception: target EXC_VEC, exception priority, latched as is_exc when stalled.
  - misalign_o pulses for one cycle on the edge where that exception redirect is applied to pc_o.
- Undefined:
  - No misalign_o port.
  - The low log2(INST_BYTES) bits of br_target_i are forced to zero before use.
- INST_BYTES = 1: the check is disabled in both cases.

Decomposition:
- Package pc_pkg:
  - State enum: IDLE, RUN, HOLD.
  - Redirect-source encoding: NONE, SEQ, BR, EXC, PEND_BR, PEND_EXC.
  - ALIGN_LSB = log2(INST_BYTES) function.
- Sub-module pc_redirect_latch: pending target, is_exc flag, overwrite-priority rule and clear. Instantiated once.
- pc_unit holds the FSM, the next-PC mux and the adder.

Test Plan:
- Reset and start: rst_i low with pc_o previously 0x40 -> pc_o = 0x0 immediately, pc_valid_o = 0. Raise start_i -> sequence 0x0, 0x4, 0x8 on successive edges.
- Stall: stall_i = 2'b10 for 3 cycles at pc_o = 0x10 -> pc_o stays 0x10. Release -> 0x14.
- Redirect while stalled: stall_i = 2'b01 with br_valid_i = 1 and target 0x200 -> redirect_pend_o = 1, pc_o held. Release -> pc_o = 0x200, redirect_pend_o = 0.
- Exception protected from later branch: in HOLD with pending exception, br_valid_i with target 0x300 -> ignored; on release pc_o = 0x80. Separately, in RUN unstalled with exc_valid_i and br_valid_i together -> pc_o = 0x80.
- Wrap and start drop: ADDR_W = 8, pc_o = 0xFC -> next pc_o = 0x00. Drop start_i while in HOLD -> pc_o = RESET_VEC, redirect_pend_o = 0.
- Alignment, with PC_ALIGN_CHECK_EN: target 0x102 -> pc_o = 0x80 and misalign_o pulses once. Without the macro -> pc_o = 0x100.
